// File: rtl/pong_paddles.sv
// pong_paddles: polls both gamepad reports once per frame and turns them into paddle positions and serve pulses.
module pong_paddles #(
  parameter int SCREEN_H = 480,
  parameter int PADDLE_H = 64,
  parameter int SPEED    = 4,
  parameter int DEADZONE = 16,
  parameter int Y_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame,
  input  logic [31:0]    rdata,
  output logic [1:0]     rreg,
  output logic [Y_W-1:0] paddle0_y,
  output logic [Y_W-1:0] paddle1_y,
  output logic [1:0]     serve,
  output logic           busy
);
  localparam int MAXY = SCREEN_H - PADDLE_H;
  localparam logic [Y_W-1:0] MID    = Y_W'(MAXY / 2);
  localparam logic [Y_W:0]   MAXY_W = (Y_W+1)'(MAXY);
  localparam logic [Y_W:0]   S1     = (Y_W+1)'(SPEED);
  localparam logic [Y_W:0]   S2     = (Y_W+1)'(2 * SPEED);
  localparam logic [8:0]     LO     = 9'(128 - DEADZONE);
  localparam logic [8:0]     HI     = 9'(128 + DEADZONE);
  typedef enum logic [1:0] {IDLE, CAP0, CAP1, UPD} state_t;
  state_t state, state_nxt;
  // Reports are kept compact as {connected, start, boost, y}
  logic [10:0] rep0, rep1;
  logic [1:0]  prev_start, start;
  logic        unused_rdata;
  assign unused_rdata = ^{rdata[30:18], rdata[7:0]};
  function automatic logic [Y_W-1:0] move(input logic [Y_W-1:0] y, input logic [10:0] r);
    logic [Y_W:0] yw, step;
    yw = {1'b0, y};
    step = r[8] ? S2 : S1;
    if (r[10] && {1'b0, r[7:0]} < LO) yw = (yw < step) ? '0 : yw - step;
    else if (r[10] && {1'b0, r[7:0]} > HI) yw = (yw + step > MAXY_W) ? MAXY_W : yw + step;
    return yw[Y_W-1:0];
  endfunction
  always_comb begin
    state_nxt = state == IDLE ? (frame ? CAP0 : IDLE) :
                state == CAP0 ? CAP1 :
                state == CAP1 ? UPD : IDLE;
    busy  = state != IDLE;
    rreg  = {1'b0, state == CAP1};
    start = {rep1[10] & rep1[9], rep0[10] & rep0[9]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rep0       <= '0;
      rep1       <= '0;
      paddle0_y  <= MID;
      paddle1_y  <= MID;
      serve      <= '0;
      prev_start <= '0;
    end else begin
      state <= state_nxt;
      serve <= '0;
      if (state == CAP0) rep0 <= {rdata[31], rdata[17:8]};
      if (state == CAP1) rep1 <= {rdata[31], rdata[17:8]};
      if (state == UPD) begin
        paddle0_y  <= move(paddle0_y, rep0);
        paddle1_y  <= move(paddle1_y, rep1);
        serve      <= start & ~prev_start;
        prev_start <= start;
      end
    end
  end
endmodule

// File: tb/tb_pong_paddles.sv
// tb_pong_paddles: table-driven frames scored through a queue, plus hand-written timing/reset/ignored-frame sequences.
module tb_pong_paddles;
  logic clk = 0, reset = 1, frame = 0;
  logic [31:0] r0 = '0, r1 = '0, rdata;
  logic [1:0] rreg, serve;
  logic [9:0] paddle0_y, paddle1_y;
  logic busy;
  int nchk = 0, nfail = 0;
  bit mon_en = 1;
  typedef struct {logic [31:0] a, b; int e0, e1; logic [1:0] es;} vec_t;
  vec_t tbl[12];
  vec_t q[$];
  always #5 clk = ~clk;
  assign rdata = (rreg == 2'd0) ? r0 : r1;
  pong_paddles dut (
    .clk(clk), .reset(reset), .frame(frame), .rdata(rdata), .rreg(rreg),
    .paddle0_y(paddle0_y), .paddle1_y(paddle1_y), .serve(serve), .busy(busy)
  );
  function automatic logic [31:0] rp(bit c, bit st, bit b, logic [7:0] y);
    return {c, 13'b0, st, b, y, 8'h00};
  endfunction
  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic reset_values(string tag);
    chk({tag, "_p0"}, paddle0_y, 208);
    chk({tag, "_p1"}, paddle1_y, 208);
    chk({tag, "_serve"}, serve, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rreg"}, rreg, 0);
  endtask
  // Scoreboard: an update sequence finishes when busy falls
  initial begin
    bit pb = 0;
    vec_t v;
    forever begin
      @(negedge clk);
      if (mon_en && pb && !busy) begin
        if (q.size() == 0) chk("sb_unexpected_update", 1, 0);
        else begin
          v = q.pop_front();
          chk("sb_p0", paddle0_y, v.e0);
          chk("sb_p1", paddle1_y, v.e1);
          chk("sb_serve", serve, v.es);
        end
      end
      pb = busy;
    end
  end
  task automatic frame_go(vec_t v);
    q.push_back(v);
    r0 = v.a;
    r1 = v.b;
    @(negedge clk) frame = 1;
    @(negedge clk) frame = 0;
    repeat (4) @(negedge clk);
    chk("serve_fall", serve, 0);
    if (q.size() != 0) begin
      chk("sb_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  initial begin
    vec_t v;
    repeat (2) @(negedge clk);
    reset = 0;
    reset_values("rst");
    // Cycle-accurate view of one poll sequence
    v = '{rp(1,1,0,8'h00), rp(1,0,0,8'hFF), 204, 212, 2'b01};
    q.push_back(v);
    r0 = v.a;
    r1 = v.b;
    @(negedge clk) frame = 1;
    @(negedge clk) frame = 0;
    chk("t_cap0_busy", busy, 1);
    chk("t_cap0_rreg", rreg, 0);
    @(negedge clk);
    chk("t_cap1_busy", busy, 1);
    chk("t_cap1_rreg", rreg, 1);
    chk("t_cap1_p0", paddle0_y, 208);
    @(negedge clk);
    chk("t_upd_busy", busy, 1);
    chk("t_upd_rreg", rreg, 0);
    chk("t_upd_serve", serve, 0);
    @(negedge clk);
    chk("t_done_busy", busy, 0);
    @(negedge clk);
    chk("t_serve_fall", serve, 0);
    chk("t_q_empty", q.size(), 0);
    // Reset while in CAP1 discards everything
    mon_en = 0;
    @(negedge clk) frame = 1;
    @(negedge clk) frame = 0;
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    reset_values("rst_cap1");
    repeat (4) @(negedge clk);
    chk("rst_cap1_still_idle", busy, 0);
    mon_en = 1;
    tbl[0]  = '{rp(1,0,0,8'h00), rp(1,0,0,8'hFF), 204, 212, 2'b00};
    tbl[1]  = '{rp(1,0,0,8'h70), rp(1,0,0,8'h90), 204, 212, 2'b00};
    tbl[2]  = '{rp(1,0,0,8'h6F), rp(1,0,0,8'h91), 200, 216, 2'b00};
    tbl[3]  = '{rp(1,0,1,8'h00), rp(1,0,1,8'hFF), 192, 224, 2'b00};
    tbl[4]  = '{rp(0,1,0,8'h00), rp(1,0,0,8'h80), 192, 224, 2'b00};
    tbl[5]  = '{rp(1,1,0,8'h80), rp(1,0,0,8'h80), 192, 224, 2'b01};
    tbl[6]  = '{rp(1,1,0,8'h80), rp(1,1,0,8'h80), 192, 224, 2'b10};
    tbl[7]  = '{rp(1,1,0,8'h80), rp(1,1,0,8'h80), 192, 224, 2'b00};
    tbl[8]  = '{rp(1,0,0,8'h80), rp(1,1,0,8'h80), 192, 224, 2'b00};
    tbl[9]  = '{rp(1,1,0,8'h80), rp(1,1,0,8'h80), 192, 224, 2'b01};
    tbl[10] = '{rp(1,1,0,8'h80), rp(0,1,0,8'h00), 192, 224, 2'b00};
    tbl[11] = '{rp(1,1,0,8'h80), rp(1,1,0,8'h80), 192, 224, 2'b10};
    foreach (tbl[i]) frame_go(tbl[i]);
    // Second frame pulse in CAP0 must be dropped
    v = '{rp(1,0,0,8'h00), rp(1,0,0,8'h80), 188, 224, 2'b00};
    q.push_back(v);
    r0 = v.a;
    r1 = v.b;
    @(negedge clk) frame = 1;
    @(negedge clk);
    chk("ign_busy_n", busy, 1);
    @(negedge clk) frame = 0;
    repeat (3) @(negedge clk);
    chk("ign_busy_n4", busy, 0);
    @(negedge clk);
    chk("ign_busy_n5", busy, 0);
    chk("ign_p0", paddle0_y, 188);
    chk("ign_q_empty", q.size(), 0);
    // Saturation at both ends, including a non-multiple-of-step approach
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    frame_go('{rp(1,0,0,8'h00), rp(1,0,0,8'hFF), 204, 212, 2'b00});
    for (int k = 1; k <= 30; k++) begin
      int e0, e1;
      e0 = (204 - 8 * k < 0) ? 0 : 204 - 8 * k;
      e1 = (212 + 8 * k > 416) ? 416 : 212 + 8 * k;
      frame_go('{rp(1,0,1,8'h00), rp(1,0,1,8'hFF), e0, e1, 2'b00});
    end
    chk("final_q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule

// File: doc/pong_paddles.md
# pong_paddles

Consumes the gamepad reports held by the SPI report receiver and turns them into paddle positions and serve requests for the pong game logic. Once per video frame it polls both report registers through the receiver's read port. It applies a dead-zone and speed rule to the Y axis, clamps each paddle to the playfield, and emits one-cycle serve pulses on start-button presses.

## Interface
Parameters:
- SCREEN_H, 480, playfield height in lines
- PADDLE_H, 64, paddle height in lines
- SPEED, 4, lines moved per frame at normal speed
- DEADZONE, 16, half-width of the Y-axis dead-zone around 0x80
- Y_W, 10, width of paddle position outputs

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame  in  1  one-cycle frame tick (vsync start)
- rdata  in  32  report word from the receiver's read port (combinational from rreg)
- rreg  out  2  report register select driven to the receiver
- paddle0_y  out  Y_W  top line of player-0 paddle
- paddle1_y  out  Y_W  top line of player-1 paddle
- serve  out  2  one-cycle serve pulse per player (bit n = player n)
- busy  out  1  high while a poll/update sequence is in progress

Report word format (decided):
- [7:0] X axis, unused
- [15:8] Y axis, unsigned, 0x80 = centre
- bit 16 = boost button
- bit 17 = start button
- bit 31 = connected

## Operation
- Reset values:
  - state = IDLE, rreg = 0, serve = 0, busy = 0
  - paddle0_y = paddle1_y = MAXY/2, where MAXY = SCREEN_H - PADDLE_H (208 at defaults)
  - stored previous start bits = 0
- FSM states are IDLE, CAP0, CAP1 and UPD:
  - IDLE: on frame, rreg <= 0 and go to CAP0; otherwise stay.
  - CAP0: rep0 <= rdata, rreg <= 1, go to CAP1.
  - CAP1: rep1 <= rdata, rreg <= 0, go to UPD.
  - UPD: update both paddles and serve, store start bits, go to IDLE.
- busy = 1 in CAP0, CAP1 and UPD.
- frame asserted while not in IDLE is ignored, with no queuing.
- Per player n in UPD, if the report's connected bit is 0:
  - paddle held
  - serve[n] = 0
  - stored start bit cleared
- Per player n in UPD, if connected:
  - step = SPEED, or 2*SPEED when boost = 1
  - Y < 0x80 - DEADZONE: move up; y <= (y < step) ? 0 : y - step
  - Y > 0x80 + DEADZONE: move down; y <= (y + step > MAXY) ? MAXY : y + step
  - otherwise hold; both thresholds are strict, so 0x70 and 0x90 hold at defaults
- Arithmetic is done in Y_W+1 bits, with no wrap at either boundary.
- serve[n] = start & ~prev_start[n], evaluated only in UPD and high for exactly one cycle.
- A held start button produces one pulse only.
- Both players are updated in the same cycle, independently.

## Timing
- frame is sampled at edge N in IDLE. rreg = 0 is visible after edge N and captured at N+1; rreg = 1 is captured at N+2.
- Paddle outputs and serve change at edge N+3. serve falls at N+4.
- busy is high from after edge N to after edge N+3.
- The minimum frame spacing for every frame to be honoured is 4 cycles.
- reset asserted in any state returns the block to reset values at the next edge; any partially captured reports are discarded.
- rdata must be stable one cycle after rreg changes; the receiver satisfies this because its read mux is combinational.

## Test plan
- Reset: assert reset in CAP1 → next edge paddle0_y = paddle1_y = 208, serve = 0, busy = 0, rreg = 0.
- Up/down: rep0 Y = 0x00, rep1 Y = 0xFF, connected, one frame → paddle0_y = 204, paddle1_y = 212 at frame edge + 3.
- Clamp/boost: rep0 Y = 0x00 with boost; 30 frames → paddle0_y steps 208, 200, … and saturates at 0. rep1 Y = 0xFF → paddle1_y saturates at 416, never wraps.
- Dead-zone: Y = 0x70 and 0x90 → no movement. Y = 0x6F → −4; Y = 0x91 → +4.
- Serve: start held high for 5 frames → exactly one serve[n] pulse, one cycle wide, at the first UPD. After release and re-press → a second pulse.
- Disconnected/ignored frame: connected = 0 with Y = 0x00 and start = 1 → paddle holds and no serve. A frame pulse in CAP0 → no extra sequence, busy low 3 cycles after the first frame.
